// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: the pattern table used by the display
// driver's encoder, the blank/invalid digit value, and the scan FSM states.
package seg_pkg;

  // Active-high segments, bit0 = a ... bit6 = g
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  localparam logic [3:0] SEG_BLANK_VAL = 4'hF;

  typedef enum logic [1:0] {
    ST_SETTLE,
    ST_CAPTURE,
    ST_HOLD
  } scan_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the seven-segment encode table: maps a 7-bit
// segment pattern back to its BCD digit, flagging anything not in the table.
module seg7_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       ok,
  output logic [3:0] value
);

  always_comb begin
    ok    = 1'b1;
    value = SEG_BLANK_VAL;
    case (pattern)
      SEG_0:   value = 4'd0;
      SEG_1:   value = 4'd1;
      SEG_2:   value = 4'd2;
      SEG_3:   value = 4'd3;
      SEG_4:   value = 4'd4;
      SEG_5:   value = 4'd5;
      SEG_6:   value = 4'd6;
      SEG_7:   value = 4'd7;
      SEG_8:   value = 4'd8;
      SEG_9:   value = 4'd9;
      default: ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive-side monitor for a multiplexed seven-segment bus: waits for each
// digit dwell to settle, decodes it once, and reports completed frames.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 5,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   SEG_SEL,
  input  logic [7:0]              SEG_DATA,
  output logic [4*NUM_DIGITS-1:0] digit_val,
  output logic [NUM_DIGITS-1:0]   digit_ok,
  output logic [NUM_DIGITS-1:0]   dp,
  output logic                    frame_valid,
  output logic                    pat_err
);

  localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);

  logic [NUM_DIGITS-1:0] s_sel;
  logic [7:0]            s_data;
  logic [3:0]            cnt;
  logic [3:0]            cnt_next;
  logic                  in_match;
  logic                  sel_onehot;
  logic [NUM_DIGITS-1:0] seen;
  logic [NUM_DIGITS-1:0] seen_next;
  logic                  dec_ok;
  logic [3:0]            dec_val;
  scan_state_t           state;

  seg7_pattern_decode u_decode (
    .pattern (s_data[6:0]),
    .ok      (dec_ok),
    .value   (dec_val)
  );

  // Stability is judged by comparing the live bus with its one-cycle-old copy
  always_comb begin
    in_match   = (SEG_SEL == s_sel) && (SEG_DATA == s_data);
    cnt_next   = '0;
    if (in_match)
      cnt_next = (cnt < STABLE_MAX) ? cnt + 4'd1 : cnt;
    sel_onehot = $onehot(s_sel);
    seen_next  = seen | s_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_sel       <= '0;
      s_data      <= '0;
      cnt         <= '0;
      state       <= ST_SETTLE;
      seen        <= '0;
      digit_val   <= {NUM_DIGITS{SEG_BLANK_VAL}};
      digit_ok    <= '0;
      dp          <= '0;
      frame_valid <= 1'b0;
      pat_err     <= 1'b0;
    end else begin
      s_sel       <= SEG_SEL;
      s_data      <= SEG_DATA;
      cnt         <= cnt_next;
      frame_valid <= 1'b0;
      pat_err     <= 1'b0;
      case (state)
        ST_SETTLE: begin
          if (cnt_next == STABLE_MAX)
            state <= ST_CAPTURE;
        end
        // s_sel/s_data still hold the settled dwell here, so a bus change
        // arriving this cycle cannot corrupt the capture.
        ST_CAPTURE: begin
          if (sel_onehot) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
              if (s_sel[i]) begin
                digit_val[4*i +: 4] <= dec_val;
                digit_ok[i]         <= dec_ok;
                dp[i]               <= s_data[7];
              end
            end
            pat_err <= !dec_ok;
            if (&seen_next) begin
              frame_valid <= 1'b1;
              seen        <= '0;
            end else begin
              seen <= seen_next;
            end
          end
          state <= in_match ? ST_HOLD : ST_SETTLE;
        end
        ST_HOLD: begin
          if (!in_match)
            state <= ST_SETTLE;
        end
        default: state <= ST_SETTLE;
      endcase
    end
  end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side monitor for the multiplexed seven-segment display bus (SEG_SEL one-hot digit select, SEG_DATA active-high segments a–g plus dp). It watches the scanned bus and filters out glitches during digit switching. Each settled segment pattern is decoded back to a BCD value. A complete frame is reported once every digit position has been captured. It sits beside the display driver as the inverse (pattern-to-digit) path, for self-check and loopback testing.

## Interface

- NUM_DIGITS, 5, number of digit positions; equals SEG_SEL width
- STABLE_CYCLES, 4, consecutive unchanged cycles required before a capture (range 1–15)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- SEG_SEL  in  NUM_DIGITS  one-hot digit select; bit i active selects digit i
- SEG_DATA  in  8  segment pattern; bit0 = a … bit6 = g, bit7 = dp
- digit_val  out  4*NUM_DIGITS  decoded value of digit i at [4i+3:4i]; 4'hF means invalid
- digit_ok  out  NUM_DIGITS  bit i = last capture of digit i decoded to a legal pattern
- dp  out  NUM_DIGITS  captured decimal point per digit
- frame_valid  out  1  one-cycle pulse when all digits are captured since the last pulse
- pat_err  out  1  one-cycle pulse on capture of an undecodable pattern

Clocking is decided: one clock; reset is asynchronous and active-low.

## Operation

- Inputs pass through one register stage: s_sel, s_data.
- A stability counter compares the raw inputs against {s_sel, s_data} every cycle.
  - Mismatch → counter cleared to 0.
  - Match → counter increments, saturating at STABLE_CYCLES.
- FSM states:
  - SETTLE: counter < STABLE_CYCLES.
  - CAPTURE: single cycle, entered when the counter reaches STABLE_CYCLES.
  - HOLD: held until the next mismatch, then back to SETTLE.
  - Only one capture happens per dwell, so a long dwell does not capture again.
- Capture is performed only if s_sel is exactly one-hot.
  - Zero or multi-hot s_sel → no capture, no error, FSM goes to HOLD.
- Decode table for s_data[6:0]: 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9.
  - Any other pattern → digit_val nibble = 4'hF, digit_ok bit = 0, pat_err pulse.
  - dp bit = s_data[7], independent of decode legality.
- Frame tracking:
  - A seen mask sets bit i on each capture of digit i, including illegal patterns.
  - When the mask becomes all-ones, frame_valid pulses in the same cycle as the capture register update, and the mask clears.
  - Repeated captures of an already-seen digit overwrite its value without affecting the mask.

## Timing

- Reset values:
  - digit_val all 4'hF; digit_ok, dp, frame_valid, pat_err all 0.
  - Seen mask 0; counter 0; FSM in SETTLE.
- Latency:
  - Raw inputs constant from edge n → s_sel/s_data valid after edge n.
  - Counter reaches STABLE_CYCLES after edge n+STABLE_CYCLES.
  - Outputs update after edge n+STABLE_CYCLES+1.
- pat_err and frame_valid are registered and high for exactly one cycle, aligned with the output update.
- An input change in the same cycle as CAPTURE does not abort that capture. It restarts SETTLE from the next cycle.
- Reset asserted mid-dwell or mid-frame clears all state immediately. The seen mask does not carry across reset.
- STABLE_CYCLES=1: any value stable for 2 edges is captured.

## Structure

- Shared package seg_pkg holds:
  - SEG_0…SEG_9 pattern constants (the same table the display driver encodes with);
  - SEG_BLANK_VAL = 4'hF;
  - the FSM state enum.
- Sub-module seg7_pattern_decode: combinational, 7-bit pattern → {ok, 4-bit value}. It is the exact inverse of the driver's encode table and is reusable elsewhere.
- Top level holds the input register, stability counter, FSM, per-digit capture registers and seen mask.

## Test plan

- Hold SEG_SEL=00001, SEG_DATA=8'h06 for 10 cycles → digit_val[3:0]=1 and digit_ok[0]=1 after edge STABLE_CYCLES+1 (5 with defaults), with exactly one capture.
- Scan digits 0–4 with patterns 3F, 5B, 4F, 66, 6D, dwell 8 each → frame_valid pulses once on the digit-4 capture; digit_val=20'h54320 (digit i holds 3F→0, 5B→2, 4F→3, 66→4, 6D→5).
- Toggle SEG_DATA between 06 and 5B every 2 cycles on digit 0 → no capture; outputs stay at reset values.
- SEG_SEL=00010, SEG_DATA=8'h49, stable → pat_err single pulse; digit_val[7:4]=F; digit_ok[1]=0.
- SEG_SEL=00011 or 00000, stable 10 cycles → no capture, no pat_err, seen mask unchanged.
- Capture digits 0–2, pulse rst_n low for 1 cycle, then scan all 5 digits → frame_valid only after all 5 post-reset captures; outputs 4'hF/0 during reset.
